fetch_redirect: RTL and testbench
=================================

Name: fetch_redirect

Overview:
- Instruction-fetch front end: the consumer of the branch unit's jump_flag.
- Owns the PC and issues in-order requests to instruction memory, with up to MAX_OUT requests in flight.
- Returns fetched instructions in order to the ID stage.
- On a taken jump, redirects the PC, discards every buffered or in-flight instruction from the old path, and drops the memory responses that are still due for it.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MAX_OUT, 2, fetch buffer depth and in-flight limit; power of two, 2..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- jump_flag  in  1  taken branch/jump from the branch unit, one-cycle qualifier.
- jump_target  in  32  redirect address, valid when jump_flag=1.
- stall  in  1  ID stage cannot accept; holds the if_* outputs.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= pc).
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses arrive in request order, 1+ cycles after grant.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  if_inst/if_pc valid toward ID.
- if_pc  out  32  PC of the presented instruction.
- if_inst  out  32  presented instruction.
- misalign_fault  out  1  one-cycle pulse, jump target not word-aligned.

Behaviour:
- Reset, synchronous, takes priority over everything:
  - pc=RESET_PC, state=BOOT, buffer empty, drop_cnt=0.
  - Outputs: imem_req=0, if_valid=0, if_pc=0, if_inst=0, misalign_fault=0.
  - Reset mid-transaction discards all state; memory is reset on the same rst.
- FSM:
  - BOOT: one cycle, then RUN.
  - RUN: normal operation.
  - HALT: entered on a misaligned jump; exits only on rst.
- Buffer:
  - Circular, MAX_OUT entries, each holding {pc, inst, filled}.
  - Pointers: alloc (wptr), fill (fptr), read (rptr).
  - Counters are log2(MAX_OUT)+1 bits.
- Issue:
  - imem_req = (state==RUN) & !buffer_full & !jump_flag; combinational, no request is issued in a jump cycle.
  - imem_addr=pc.
  - On imem_req & imem_gnt: allocate an entry at wptr with pc, then pc <= pc+4; pc wraps 32'hFFFF_FFFC -> 0.
  - Without a grant, pc and imem_addr stay stable.
- Response:
  - drop_cnt>0: imem_rvalid decrements drop_cnt and the data is discarded.
  - drop_cnt=0: the entry at fptr gets inst and filled=1, and fptr advances.
  - Response latency is 1 cycle minimum, so no response can target an entry allocated in the same cycle.
- Output:
  - if_valid = head filled; if_pc and if_inst come from the head entry; combinational from registers.
  - Head pops when if_valid & !stall.
  - stall=1 holds all if_* stable.
  - Issue, fill and pop in the same cycle are legal.
- Jump (jump_flag=1 in RUN):
  - Priority over stall, gnt and pop.
  - All entries are invalidated: wptr=fptr=rptr; if_valid=0 from the next cycle.
  - drop_cnt <= drop_cnt + (allocated-unfilled entries) - (imem_rvalid this cycle ? 1 : 0).
  - pc <= jump_target; issue resumes the next cycle, even while drop_cnt>0.
  - The next new-path instruction reaches if_valid after the drops are consumed.
- Misaligned jump (jump_target[1:0]!=0):
  - Same flush as a normal jump.
  - misalign_fault=1 for the next cycle.
  - pc <= {jump_target[31:2],2'b00}; state=HALT.
- HALT:
  - imem_req=0 and if_valid=0.
  - Outstanding responses are still dropped.
  - Further jump_flag is ignored.
- jump_flag in BOOT or HALT is ignored.
- Back-to-back jumps: the second recomputes drop_cnt from the live state; no old-path instruction is ever presented.

Test Plan:
- Reset with RESET_PC=32'h100; memory always grants with 1-cycle response latency, stall=0 -> imem_addr=0x100,0x104,0x108 on consecutive cycles; if_valid=1 with if_pc=0x100 two cycles after BOOT ends.
- Hold stall=1 for 5 cycles with MAX_OUT=2 -> at most 2 allocated entries; imem_req=0 while full; if_pc/if_inst constant; no instruction lost or duplicated after release.
- jump_flag with target 0x2000 while 2 requests are in flight and none has responded -> drop_cnt=2; the next 2 rvalid are discarded; first if_valid has if_pc=0x2000.
- jump_flag coincident with imem_rvalid and stall=1 -> if_valid=0 the next cycle; drop_cnt counts the coincident response as consumed; no stale if_pc is presented.
- jump to 0x3002 -> misalign_fault pulses 1 cycle; imem_req=0 forever; pending rvalid are dropped; rst resumes fetch at RESET_PC.
- pc=32'hFFFF_FFFC granted -> next imem_addr=0x0; assert rst mid-stream -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/fetch_redirect.sv
// -----------------------------------------------------------------------------
// fetch_redirect
//   Instruction-fetch front end. Owns the PC, issues in-order requests to
//   instruction memory (at most MAX_OUT allocated buffer entries), and returns
//   fetched words in order to ID. A taken jump from the branch unit flushes
//   every buffered or in-flight old-path instruction, redirects the PC and
//   arranges for the memory responses still due on the old path to be dropped.
//
// Parameters
//   RESET_PC    PC loaded on reset.
//   MAX_OUT     fetch buffer depth / in-flight limit (power of two, 2..8).
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   jump_flag, jump_target   taken redirect and its address (one-cycle qualifier)
//   stall                    ID cannot accept; holds if_* outputs
//   imem_req, imem_addr      fetch request valid / address (= pc)
//   imem_gnt                 memory accepts the request this cycle
//   imem_rvalid, imem_rdata  in-order response, >= 1 cycle after grant
//   if_valid, if_pc, if_inst instruction presented to ID
//   misalign_fault           one-cycle pulse after a non-word-aligned jump
// -----------------------------------------------------------------------------
module fetch_redirect #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MAX_OUT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag,
   input  logic [31:0] jump_target,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        misalign_fault
);

   localparam int AW = $clog2(MAX_OUT);
   localparam int CW = AW + 1;
   // Drops are not bounded by the buffer depth: issue resumes right after a
   // jump while old-path responses are still owed, and repeated jumps against
   // a slow memory keep adding to the debt. Give the counter ample headroom.
   localparam int DW = 8;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q;
   logic [CW-1:0]   wptr_q, fptr_q, rptr_q;
   logic [DW-1:0]   drop_cnt;
   logic            fault_q;

   logic [31:0]        buf_pc   [MAX_OUT];
   logic [31:0]        buf_inst [MAX_OUT];
   logic [MAX_OUT-1:0] buf_filled;

   logic [CW-1:0]   occupancy, pending;
   logic [AW-1:0]   widx, fidx, ridx;
   logic            run, full, take_jump, misaligned;
   logic            issue, fill, pop;
   logic [DW-1:0]   drop_sum, drop_jump;

   // ---------------------------------------------------------------------------
   // Occupancy. Pointers carry one extra wrap bit so full and empty differ.
   // ---------------------------------------------------------------------------
   assign occupancy  = wptr_q - rptr_q;   // allocated entries
   assign pending    = wptr_q - fptr_q;   // allocated, still waiting for data
   assign full       = (occupancy == CW'(MAX_OUT));
   assign widx       = wptr_q[AW-1:0];
   assign fidx       = fptr_q[AW-1:0];
   assign ridx       = rptr_q[AW-1:0];

   assign run        = (state_q == S_RUN);
   assign take_jump  = run & jump_flag;
   assign misaligned = (jump_target[1:0] != 2'b00);

   // No request in a jump cycle: the address would belong to the dead path.
   assign imem_req   = run & ~full & ~jump_flag;
   assign imem_addr  = pc_q;
   assign issue      = imem_req & imem_gnt;

   // A response fills the oldest unfilled entry only once the old-path debt
   // is paid. The pending check keeps a stray rvalid from touching the buffer.
   assign fill       = imem_rvalid & (drop_cnt == '0) & run & ~take_jump &
                       (pending != '0);

   // Head is filled only when the buffer is non-empty; outputs are zeroed
   // when nothing is presented so no stale PC ever leaks toward ID.
   assign if_valid   = run & (occupancy != '0) & buf_filled[ridx];
   assign if_pc      = if_valid ? buf_pc[ridx]   : 32'h0;
   assign if_inst    = if_valid ? buf_inst[ridx] : 32'h0;
   assign pop        = if_valid & ~stall & ~take_jump;

   assign misalign_fault = fault_q;

   // Debt after a flush: everything allocated but unfilled becomes a drop.
   // A response arriving in the jump cycle either pays an existing drop or
   // fills an entry that is being discarded; both retire one owed response.
   assign drop_sum   = drop_cnt + DW'(pending);
   assign drop_jump  = (imem_rvalid && drop_sum != '0) ? drop_sum - DW'(1) : drop_sum;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_BOOT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   if (take_jump && misaligned) state_d = S_HALT;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_BOOT;
      endcase
   end

   // ---------------------------------------------------------------------------
   // PC, pointers, drop counter, fault pulse
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         wptr_q   <= '0;
         fptr_q   <= '0;
         rptr_q   <= '0;
         drop_cnt <= '0;
         fault_q  <= 1'b0;
      end else begin
         fault_q <= take_jump & misaligned;
         if (take_jump) begin
            pc_q     <= {jump_target[31:2], 2'b00};
            fptr_q   <= wptr_q;
            rptr_q   <= wptr_q;
            drop_cnt <= drop_jump;
         end else begin
            // pc wraps FFFF_FFFC -> 0 through natural 32-bit overflow
            if (issue) begin
               pc_q   <= pc_q + 32'd4;
               wptr_q <= wptr_q + CW'(1);
            end
            if (fill) fptr_q <= fptr_q + CW'(1);
            if (pop)  rptr_q <= rptr_q + CW'(1);
            if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - DW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Buffer storage. Issue, fill and pop never target the same slot in one
   // cycle: issue needs a free slot, fill needs an allocated unfilled slot,
   // pop needs a filled head.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_filled <= '0;
      end else if (take_jump) begin
         buf_filled <= '0;
      end else begin
         if (issue) buf_filled[widx] <= 1'b0;
         if (fill)  buf_filled[fidx] <= 1'b1;
         if (pop)   buf_filled[ridx] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) buf_pc[widx]   <= pc_q;
      if (fill)  buf_inst[fidx] <= imem_rdata;
   end

endmodule

// File: tb/tb_fetch_redirect.sv
module tb_fetch_redirect;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jump_flag = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        misalign_fault;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_redirect #(.RESET_PC(32'h100), .MAX_OUT(2)) dut (
      .clk(clk), .rst(rst), .jump_flag(jump_flag), .jump_target(jump_target),
      .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .misalign_fault(misalign_fault)
   );

   always #5 clk = ~clk;

   // Memory model: in-order responses exactly `lat` cycles after grant,
   // data = ~address. Reset on the same rst as the DUT.
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t mq[$];
   int    mcyc = 0;
   int    lat  = 1;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         imem_rvalid <= 1'b0;
         imem_rdata  <= 32'h0;
      end else begin
         if (imem_req && imem_gnt) mq.push_back('{imem_addr, mcyc + lat - 1});
         if (mq.size() > 0 && mq[0].due <= mcyc) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= ~mq[0].addr;
            mq.delete(0);
         end else begin
            imem_rvalid <= 1'b0;
         end
      end
      mcyc++;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Advance one cycle, drive this cycle's inputs, let combinational settle.
   task automatic cyc(input logic j, input logic [31:0] t, input logic s);
      @(posedge clk); #1;
      jump_flag = j; jump_target = t; stall = s;
      #2;
   endtask

   // Leaves the bench inside C0 (first BOOT cycle after reset release).
   task automatic do_reset(input int l);
      rst = 1'b1; jump_flag = 1'b0; stall = 1'b0; imem_gnt = 1'b1; lat = l;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #2;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(posedge clk); #3;
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end
      n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", if_valid); end
      n_tests++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_if: pc %h inst %h want 0", if_pc, if_inst); end
      n_tests++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0b want 0", misalign_fault); end
      n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL reset_addr: got %h want 100", imem_addr); end
   endtask

   task automatic test_fetch;
      do_reset(1);
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %0b want 0", imem_req); end
      cyc(0, 0, 0); // C1
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_c1: req %0b addr %h want 1/100", imem_req, imem_addr); end
      cyc(0, 0, 0); // C2
      n_tests++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL fetch_c2: addr %h want 104", imem_addr); end
      cyc(0, 0, 0); // C3: buffer full, head presented
      n_tests++; if (imem_addr !== 32'h108 || imem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_c3: req %0b addr %h want 0/108", imem_req, imem_addr); end
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== ~32'h100) begin n_fail++; $display("FAIL fetch_first: v %0b pc %h inst %h want 1/100/%h", if_valid, if_pc, if_inst, ~32'h100); end
      cyc(0, 0, 0); // C4
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin n_fail++; $display("FAIL fetch_second: v %0b pc %h want 1/104", if_valid, if_pc); end
   endtask

   task automatic test_no_grant;
      do_reset(1);
      imem_gnt = 1'b0;
      cyc(0, 0, 0); // C1 not granted
      cyc(0, 0, 0); // C2
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL nogrant_hold: req %0b addr %h want 1/100", imem_req, imem_addr); end
      imem_gnt = 1'b1;
      cyc(0, 0, 0); // C3
      n_tests++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL nogrant_adv: addr %h want 104", imem_addr); end
   endtask

   task automatic test_stall;
      logic [31:0] exp_pc;
      int pops;
      do_reset(1);
      cyc(0, 0, 1); cyc(0, 0, 1); // C1, C2
      for (int k = 3; k <= 5; k++) begin
         cyc(0, 0, 1);
         n_tests++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== ~32'h100) begin
            n_fail++; $display("FAIL stall_hold_c%0d: req %0b v %0b pc %h inst %h", k, imem_req, if_valid, if_pc, if_inst); end
      end
      exp_pc = 32'h100; pops = 0;
      for (int k = 6; k <= 13; k++) begin
         cyc(0, 0, 0);
         if (if_valid) begin
            n_tests++; if (if_pc !== exp_pc || if_inst !== ~exp_pc) begin n_fail++; $display("FAIL stall_order: pc %h inst %h want %h", if_pc, if_inst, exp_pc); end
            exp_pc += 32'd4; pops++;
         end
      end
      n_tests++; if (pops !== 6) begin n_fail++; $display("FAIL stall_pops: got %0d want 6", pops); end
   endtask

   task automatic test_jump_inflight;
      int first;
      do_reset(4);
      cyc(0, 0, 0); cyc(0, 0, 0); // C1, C2: two grants, no responses yet
      cyc(1, 32'h2000, 0);        // C3
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL jump_req: got %0b want 0", imem_req); end
      cyc(0, 0, 0);               // C4
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || if_valid !== 1'b0) begin n_fail++; $display("FAIL jump_resume: req %0b addr %h v %0b", imem_req, imem_addr, if_valid); end
      n_tests++; if (dut.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL jump_drop: got %0d want 2", dut.drop_cnt); end
      first = 0;
      for (int k = 5; k <= 20 && first == 0; k++) begin
         cyc(0, 0, 0);
         if (if_valid) first = k;
      end
      n_tests++; if (first !== 9 || if_pc !== 32'h2000 || if_inst !== ~32'h2000) begin n_fail++; $display("FAIL jump_first: cycle %0d pc %h inst %h want 9/2000", first, if_pc, if_inst); end
   endtask

   task automatic test_jump_rvalid_stall;
      do_reset(1);
      cyc(0, 0, 1); cyc(0, 0, 1);  // C1, C2
      cyc(1, 32'h3000, 1);         // C3: response for 0x104 arrives now
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin n_fail++; $display("FAIL jrs_pre: v %0b pc %h want 1/100", if_valid, if_pc); end
      cyc(0, 0, 0);                // C4
      n_tests++; if (if_valid !== 1'b0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL jrs_flush: v %0b pc %h want 0/0", if_valid, if_pc); end
      n_tests++; if (dut.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL jrs_drop: got %0d want 0", dut.drop_cnt); end
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL jrs_issue: req %0b addr %h", imem_req, imem_addr); end
      cyc(0, 0, 0);                // C5
      n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL jrs_c5: v %0b want 0", if_valid); end
      cyc(0, 0, 0);                // C6
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 || if_inst !== ~32'h3000) begin n_fail++; $display("FAIL jrs_new: v %0b pc %h inst %h", if_valid, if_pc, if_inst); end
   endtask

   task automatic test_back_to_back;
      int first;
      do_reset(2);
      cyc(0, 0, 0); cyc(0, 0, 0);  // C1, C2
      cyc(1, 32'h4000, 0);         // C3: 0x100 response coincides
      cyc(1, 32'h5000, 0);         // C4: 0x104 response coincides
      n_tests++; if (imem_req !== 1'b0 || dut.drop_cnt !== 8'd1) begin n_fail++; $display("FAIL b2b_c4: req %0b drop %0d want 0/1", imem_req, dut.drop_cnt); end
      cyc(0, 0, 0);                // C5
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h5000 || dut.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_c5: req %0b addr %h drop %0d", imem_req, imem_addr, dut.drop_cnt); end
      first = 0;
      for (int k = 6; k <= 20 && first == 0; k++) begin
         cyc(0, 0, 0);
         if (if_valid) first = k;
      end
      n_tests++; if (first !== 8 || if_pc !== 32'h5000) begin n_fail++; $display("FAIL b2b_first: cycle %0d pc %h want 8/5000", first, if_pc); end
   endtask

   task automatic test_misalign;
      int bad;
      do_reset(3);
      cyc(0, 0, 0); cyc(0, 0, 0);  // C1, C2
      cyc(1, 32'h3002, 0);         // C3
      n_tests++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL mis_early: got %0b want 0", misalign_fault); end
      cyc(0, 0, 0);                // C4
      n_tests++; if (misalign_fault !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL mis_pulse: f %0b req %0b addr %h", misalign_fault, imem_req, imem_addr); end
      cyc(1, 32'h6000, 0);         // C5: ignored in HALT
      n_tests++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL mis_width: got %0b want 0", misalign_fault); end
      bad = 0;
      for (int k = 6; k <= 10; k++) begin
         cyc(0, 0, 0);
         if (imem_req !== 1'b0 || if_valid !== 1'b0) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL mis_halt: %0d active cycles want 0", bad); end
      n_tests++; if (imem_addr !== 32'h3000 || dut.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mis_state: addr %h drop %0d want 3000/0", imem_addr, dut.drop_cnt); end
      do_reset(1);
      cyc(0, 0, 0);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL mis_restart: req %0b addr %h", imem_req, imem_addr); end
   endtask

   task automatic test_wrap_reset;
      do_reset(1);
      cyc(0, 0, 0);                 // C1
      cyc(1, 32'hFFFF_FFF8, 0);     // C2
      cyc(0, 0, 0);                 // C3
      n_tests++; if (imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_c3: addr %h", imem_addr); end
      cyc(0, 0, 0);                 // C4
      n_tests++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_c4: req %0b addr %h", imem_req, imem_addr); end
      cyc(0, 0, 0);                 // C5
      n_tests++; if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_c5: addr %h pc %h", imem_addr, if_pc); end
      cyc(0, 0, 0);                 // C6
      n_tests++; if (if_pc !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_c6: pc %h req %0b", if_pc, imem_req); end
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #2;
      n_tests++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || misalign_fault !== 1'b0 || imem_addr !== 32'h100) begin
         n_fail++; $display("FAIL midreset: req %0b v %0b pc %h inst %h f %0b addr %h", imem_req, if_valid, if_pc, if_inst, misalign_fault, imem_addr); end
      rst = 1'b0;
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_no_grant;
      test_stall;
      test_jump_inflight;
      test_jump_rvalid_stall;
      test_back_to_back;
      test_misalign;
      test_wrap_reset;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
